// File: rtl/video_palette_pkg.sv
// Shared types and constants for the video palette block: commit FSM states,
// the pending-write record carried through the FIFO, and the reset greyscale ramp.
package xv;

  localparam int PAL_ENTRIES = 16;
  localparam int PAL_COLOR_W = 12;
  localparam int PAL_INDEX_W = 4;

  typedef enum logic [1:0] {
    PAL_IDLE,
    PAL_WAIT_BLANK,
    PAL_COMMIT
  } pal_state_t;

  typedef struct packed {
    logic [PAL_INDEX_W-1:0] addr;
    logic [PAL_COLOR_W-1:0] data;
  } pal_wr_t;

  function automatic logic [PAL_COLOR_W-1:0] pal_reset_color(input logic [PAL_INDEX_W-1:0] idx);
    return {idx, idx, idx};
  endfunction

endpackage

// File: rtl/video_palette_fifo.sv
// Small synchronous FIFO holding CPU palette writes until they can be committed.
// Push while full is honoured only when a pop happens in the same cycle.
module video_palette_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_ni,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/video_palette.sv
// Palette lookup stage behind the video timing generator: 2-cycle index->RGB pipeline
// with realigned syncs, plus CPU writes queued and committed only during blanking.
module video_palette
  import xv::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter bit WR_ANYTIME = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_ni,
  input  logic [PAL_INDEX_W-1:0] pal_index_i,
  input  logic                   hsync_i,
  input  logic                   vsync_i,
  input  logic                   dv_de_i,
  input  logic                   pal_wr_i,
  input  logic [PAL_INDEX_W-1:0] pal_wr_addr_i,
  input  logic [PAL_COLOR_W-1:0] pal_wr_data_i,
  output logic                   pal_wr_ready_o,
  output logic                   pal_pending_o,
  input  logic [PAL_INDEX_W-1:0] pal_rd_addr_i,
  output logic [PAL_COLOR_W-1:0] pal_rd_data_o,
  output logic [3:0]             red_o,
  output logic [3:0]             green_o,
  output logic [3:0]             blue_o,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic                   dv_de_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [PAL_INDEX_W-1:0] s1_index_q, s1_index_d;
  logic                   s1_hsync_q, s1_hsync_d;
  logic                   s1_vsync_q, s1_vsync_d;
  logic                   s1_de_q, s1_de_d;
  logic [PAL_COLOR_W-1:0] s2_rgb_q, s2_rgb_d;
  logic                   s2_hsync_q, s2_hsync_d;
  logic                   s2_vsync_q, s2_vsync_d;
  logic                   s2_de_q, s2_de_d;
  logic [PAL_COLOR_W-1:0] pal_q [PAL_ENTRIES];
  logic [PAL_COLOR_W-1:0] pal_d [PAL_ENTRIES];
  logic [PAL_COLOR_W-1:0] rd_data_q, rd_data_d;
  pal_state_t             state_q, state_d;

  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  pal_wr_t                fifo_din, fifo_dout;
  logic [CW-1:0]          fifo_count;
  logic                   commit_ok;

  assign fifo_push      = pal_wr_i & pal_wr_ready_o;
  assign fifo_din       = '{addr: pal_wr_addr_i, data: pal_wr_data_i};
  assign pal_wr_ready_o = ~fifo_full;
  assign pal_pending_o  = ~fifo_empty;
  // Both the live DE and the S1 copy must be low, so the S2 lookup never sees a commit mid-line.
  assign commit_ok      = WR_ANYTIME | (~dv_de_i & ~s1_de_q);

  video_palette_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH($bits(pal_wr_t))
  ) u_fifo (
    .clk      (clk),
    .reset_ni (reset_ni),
    .push     (fifo_push),
    .din      (fifo_din),
    .pop      (fifo_pop),
    .dout     (fifo_dout),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      PAL_IDLE:       if (!fifo_empty) state_d = PAL_WAIT_BLANK;
      PAL_WAIT_BLANK: if (commit_ok)   state_d = PAL_COMMIT;
      PAL_COMMIT: begin
        fifo_pop = commit_ok & ~fifo_empty;
        if (fifo_empty)                                state_d = PAL_IDLE;
        else if (!commit_ok)                           state_d = PAL_WAIT_BLANK;
        else if (fifo_count == CW'(1) && !fifo_push)   state_d = PAL_IDLE;
      end
      default:        state_d = PAL_IDLE;
    endcase
  end

  always_comb begin
    s1_index_d = pal_index_i;
    s1_hsync_d = hsync_i;
    s1_vsync_d = vsync_i;
    s1_de_d    = dv_de_i;
    s2_rgb_d   = s1_de_q ? pal_q[s1_index_q] : '0;
    s2_hsync_d = s1_hsync_q;
    s2_vsync_d = s1_vsync_q;
    s2_de_d    = s1_de_q;
    rd_data_d  = pal_q[pal_rd_addr_i];
    pal_d      = pal_q;
    if (fifo_pop) pal_d[fifo_dout.addr] = fifo_dout.data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= PAL_IDLE;
      s1_index_q <= '0;
      s1_hsync_q <= 1'b0;
      s1_vsync_q <= 1'b0;
      s1_de_q    <= 1'b0;
      s2_rgb_q   <= '0;
      s2_hsync_q <= 1'b0;
      s2_vsync_q <= 1'b0;
      s2_de_q    <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < PAL_ENTRIES; i++) pal_q[i] <= pal_reset_color(PAL_INDEX_W'(i));
    end else begin
      state_q    <= state_d;
      s1_index_q <= s1_index_d;
      s1_hsync_q <= s1_hsync_d;
      s1_vsync_q <= s1_vsync_d;
      s1_de_q    <= s1_de_d;
      s2_rgb_q   <= s2_rgb_d;
      s2_hsync_q <= s2_hsync_d;
      s2_vsync_q <= s2_vsync_d;
      s2_de_q    <= s2_de_d;
      rd_data_q  <= rd_data_d;
      pal_q      <= pal_d;
    end
  end

  assign red_o         = s2_rgb_q[11:8];
  assign green_o       = s2_rgb_q[7:4];
  assign blue_o        = s2_rgb_q[3:0];
  assign hsync_o       = s2_hsync_q;
  assign vsync_o       = s2_vsync_q;
  assign dv_de_o       = s2_de_q;
  assign pal_rd_data_o = rd_data_q;

endmodule
